fpu_addsub_ctrl: RTL and testbench
==================================

FPU_ADDSUB_CTRL -- requirements
Module: fpu_addsub_ctrl

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width; only 8 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the operand handshake.
REQ-005 SHALL have ports in_a and in_b, input, 32 each, IEEE-754 single-precision operands.
REQ-006 SHALL have port in_sub, input, 1: 1 = a-b, 0 = a+b.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-008 SHALL have port out_result, output, 32, IEEE-754 single-precision result.
REQ-009 SHALL have port out_flags, output, 3: bit0 zero, bit1 overflow, bit2 underflow.

Function
REQ-010 SHALL use FSM states IDLE, ALIGN, ADD, NORM, DONE.
REQ-011 SHALL assert in_ready only in IDLE, and SHALL capture in_a, in_b and in_sub on in_valid&&in_ready, then go to ALIGN.
REQ-012 SHALL step ALIGN->ADD->NORM->DONE unconditionally, one cycle each, so out_valid rises exactly 4 cycles after the accept edge.
REQ-013 SHALL hold DONE with out_valid=1 and out_result/out_flags stable until out_ready=1, then go to IDLE; minimum issue interval is 5 cycles.
REQ-014 SHALL treat exponent 0 (zero or denormal) as signed zero with mantissa 0 (flush-to-zero).
REQ-015 SHALL set effective sign of b = b[31]^in_sub and effective op = subtract when sign_a != effective sign_b.
REQ-016 ALIGN: SHALL select as "big" the operand with larger {exp,mant} (a on tie), and SHALL right-shift small's 24-bit significand (hidden 1 included) by exp_big-exp_small, giving 0 when the difference is >=24, with truncation and no guard/round/sticky bits.
REQ-017 ADD: SHALL form 25-bit sum = {0,sig_big} +/- {0,sig_small_aligned}; result sign = sign of big.
REQ-018 NORM: SHALL apply the leading-one normalizer (25-bit src, 23-bit fraction, 5-bit shift count s) and compute signed exp_out = exp_big + 1 - s.
REQ-019 SHALL output +0 (0x00000000, zero flag) when sum == 0, including exact cancellation.
REQ-020 SHALL output {sign,0xFF,0}, overflow flag set, when exp_out >= 255.
REQ-021 SHALL output {sign,31'd0}, underflow and zero flags set, when exp_out <= 0.
REQ-022 Specials: any NaN operand, or Inf minus Inf in effective terms, SHALL output 0x7FC00000; otherwise any Inf operand SHALL output that Inf with its effective sign; flags 0; fixed latency unchanged.
REQ-023 SHALL keep out_result and out_flags driven only from registers, with no combinational path from inputs to outputs.

Reset
REQ-024 rst SHALL force state IDLE, out_valid=0, out_result=0, out_flags=0 and in_ready=1 on the next edge.
REQ-025 rst SHALL take precedence over every handshake; an in-flight operation is discarded with no result.
REQ-026 in_ready SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-027 Shared package fpu_pkg SHALL hold the state enum, field widths (EXP_W=8, FRAC_W=23), the QNAN constant 0x7FC00000 and the flag bit indices.
REQ-028 SHALL instantiate exactly one sub-module, FPU_normalize, in the NORM stage; all other logic is inline.

Verification
REQ-029 0x3F800000 + 0x3F800000 -> 0x40000000, flags 000, out_valid 4 cycles after the accept.
REQ-030 0x3F800000 - 0x3F800000 (in_sub=1) -> 0x00000000, flags 001.
REQ-031 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 010; 0x7F800000 - 0x7F800000 -> 0x7FC00000.
REQ-032 0x3F800000 + 0x33800000 -> 0x3F800000, showing truncation of the aligned-out bit.
REQ-033 out_ready held low 3 cycles in DONE -> out_result stable, in_ready 0, and a new in_valid is not accepted.
REQ-034 rst asserted during ADD -> next cycle IDLE, out_valid 0, in_ready 1; the following op 0x40000000 + 0x3F800000 -> 0x40400000.

Source files
------------

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the single-precision add/subtract controller:
// controller state encoding, IEEE-754 field widths, the canonical quiet NaN
// and the bit positions inside the 3-bit status flag vector.
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W   = 8;             // exponent field width
    localparam int FRAC_W  = 23;            // stored fraction width
    localparam int SIG_W   = FRAC_W + 1;    // significand incl. hidden one
    localparam int SUM_W   = SIG_W + 1;     // significand sum incl. carry
    localparam int SHIFT_W = 5;             // normalizer shift count width

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside out_flags
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_UNF  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/FPU_normalize.sv
// ---------------------------------------------------------------------------
// FPU_normalize
// Leading-one normalizer for the 25-bit significand sum.
//   src   : unsigned sum, bit 24 is the carry position
//   frac  : 23 fraction bits found directly below the leading one (truncated)
//   shift : left shift applied, 0 when the leading one sits in bit 24
//   zero  : src is all zeros (frac/shift are then meaningless)
// Purely combinational.
// ---------------------------------------------------------------------------
module FPU_normalize
    import fpu_pkg::*;
(
    input  logic [SUM_W-1:0]   src,
    output logic [FRAC_W-1:0]  frac,
    output logic [SHIFT_W-1:0] shift,
    output logic               zero
);

    always_comb begin
        shift = '0;
        // Ascending scan: the highest set bit writes last and wins.
        for (int i = 0; i < SUM_W; i++) begin
            if (src[i]) begin
                shift = SHIFT_W'(SUM_W - 1 - i);
            end
        end
        // After the shift the leading one is in bit 24; the fraction is bits
        // 23..1, so bit 0 of the shifted value is dropped (truncation).
        frac = FRAC_W'((src << shift) >> 1);
        zero = (src == '0);
    end

endmodule

// File: rtl/fpu_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_addsub_ctrl
// Multi-cycle IEEE-754 single-precision adder/subtractor with flush-to-zero
// and truncation. One operation is in flight at a time; the controller walks
// IDLE -> ALIGN -> ADD -> NORM -> DONE and holds DONE until the result is
// taken.
//
// Ports
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_a, in_b, in_sub)
//   in_a, in_b            : single-precision operands
//   in_sub                : 1 = a - b, 0 = a + b
//   out_valid / out_ready : result handshake (out_result, out_flags)
//   out_result            : single-precision result
//   out_flags             : {underflow, overflow, zero}
//   state                 : current controller state, for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. Once out_valid is 1, out_result and
// out_flags stay constant until the edge where out_ready is also 1.
// All outputs are registers.
// ---------------------------------------------------------------------------
module fpu_addsub_ctrl
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags,
    output state_t      state
);

    // Signed exponent width for the post-normalization exponent (-23..256)
    localparam int EO_W = EXP_W + 2;

    // Captured operands
    logic [31:0] a_q, b_q;
    logic        sub_q;

    // ALIGN stage registers (stay valid through ADD and NORM)
    logic              sign_big_q;
    logic [EXP_W-1:0]  exp_big_q;
    logic [SIG_W-1:0]  sig_big_q;
    logic [SIG_W-1:0]  sig_small_q;
    logic              eff_sub_q;
    logic              special_q;
    logic [31:0]       special_val_q;

    // ADD stage register
    logic [SUM_W-1:0]  sum_q;

    // ---------------------------------------------------------------- ALIGN
    logic              sign_a, sign_b;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [FRAC_W-1:0] frac_a, frac_b;
    logic [SIG_W-1:0]  sig_a, sig_b;
    logic              nan_a, nan_b, inf_a, inf_b;
    logic              a_big, eff_sub;
    logic              big_sign;
    logic [EXP_W-1:0]  big_exp, small_exp, exp_diff;
    logic [SIG_W-1:0]  big_sig, small_sig, small_sig_al;
    logic              special_c;
    logic [31:0]       special_val_c;

    always_comb begin
        sign_a = a_q[31];
        exp_a  = a_q[30 -: EXP_W];
        frac_a = a_q[FRAC_W-1:0];
        // Subtraction is folded into the sign of b.
        sign_b = b_q[31] ^ sub_q;
        exp_b  = b_q[30 -: EXP_W];
        frac_b = b_q[FRAC_W-1:0];

        nan_a = (&exp_a) && (frac_a != '0);
        nan_b = (&exp_b) && (frac_b != '0);
        inf_a = (&exp_a) && (frac_a == '0);
        inf_b = (&exp_b) && (frac_b == '0);

        // Exponent 0 (zero or denormal) flushes to a zero significand.
        sig_a = (exp_a == '0) ? '0 : {1'b1, frac_a};
        sig_b = (exp_b == '0) ? '0 : {1'b1, frac_b};

        eff_sub = (sign_a != sign_b);

        // Larger magnitude becomes "big"; a wins a tie.
        a_big     = {exp_a, sig_a} >= {exp_b, sig_b};
        big_sign  = a_big ? sign_a : sign_b;
        big_exp   = a_big ? exp_a  : exp_b;
        big_sig   = a_big ? sig_a  : sig_b;
        small_exp = a_big ? exp_b  : exp_a;
        small_sig = a_big ? sig_b  : sig_a;

        exp_diff     = big_exp - small_exp;
        small_sig_al = (exp_diff >= EXP_W'(SIG_W)) ? '0 : (small_sig >> exp_diff);

        special_c     = 1'b1;
        special_val_c = QNAN;
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            special_val_c = QNAN;
        end else if (inf_a) begin
            special_val_c = {sign_a, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (inf_b) begin
            special_val_c = {sign_b, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            special_c = 1'b0;
        end
    end

    // ------------------------------------------------------------------ ADD
    // big >= small in magnitude, so the difference never goes negative.
    logic [SUM_W-1:0] sum_c;

    always_comb begin
        if (eff_sub_q) begin
            sum_c = {1'b0, sig_big_q} - {1'b0, sig_small_q};
        end else begin
            sum_c = {1'b0, sig_big_q} + {1'b0, sig_small_q};
        end
    end

    // ----------------------------------------------------------------- NORM
    logic [FRAC_W-1:0]  norm_frac;
    logic [SHIFT_W-1:0] norm_shift;
    logic               norm_zero;

    FPU_normalize u_normalize (
        .src   (sum_q),
        .frac  (norm_frac),
        .shift (norm_shift),
        .zero  (norm_zero)
    );

    logic [EO_W-1:0] exp_out;   // two's complement
    logic            exp_neg, exp_ovf, exp_unf;
    logic [31:0]     result_c;
    logic [2:0]      flags_c;

    always_comb begin
        exp_out = EO_W'(exp_big_q) + EO_W'(1) - EO_W'(norm_shift);
        exp_neg = exp_out[EO_W-1];
        exp_ovf = !exp_neg && (exp_out >= EO_W'({EXP_W{1'b1}}));
        exp_unf = exp_neg || (exp_out == '0);

        result_c = '0;
        flags_c  = '0;
        if (special_q) begin
            result_c = special_val_q;
        end else if (norm_zero) begin
            // Exact cancellation and zero+zero both give +0.
            flags_c[FLAG_ZERO] = 1'b1;
        end else if (exp_ovf) begin
            result_c          = {sign_big_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_c[FLAG_OVF] = 1'b1;
        end else if (exp_unf) begin
            result_c           = {sign_big_q, 31'd0};
            flags_c[FLAG_UNF]  = 1'b1;
            flags_c[FLAG_ZERO] = 1'b1;
        end else begin
            result_c = {sign_big_q, exp_out[EXP_W-1:0], norm_frac};
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        sub_q    <= in_sub;
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_big_q    <= big_sign;
                    exp_big_q     <= big_exp;
                    sig_big_q     <= big_sig;
                    sig_small_q   <= small_sig_al;
                    eff_sub_q     <= eff_sub;
                    special_q     <= special_c;
                    special_val_q <= special_val_c;
                    state         <= ADD;
                end
                ADD: begin
                    sum_q <= sum_c;
                    state <= NORM;
                end
                NORM: begin
                    out_result <= result_c;
                    out_flags  <= flags_c;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_ctrl
// Scoreboard bench: the driver pushes the expected {flags, result} and the
// accept edge number into queues; a monitor process pops and compares at
// every result handshake and checks the out_valid latency on its rising edge.
// ---------------------------------------------------------------------------
module tb_fpu_addsub_ctrl;
  import fpu_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  state_t      state;

  always #5 clk = ~clk;

  int cyc = 0;   // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  fpu_addsub_ctrl #(.EXP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .state      (state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [34:0] exp_q[$];   // {flags, result}
  int          acc_q[$];   // edge number of each tracked accept
  int          errors = 0;
  int          checks = 0;
  bit          ready_random = 1'b0;
  bit          ready_force  = 1'b1;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: real-valued view of the operation on integer
  // significands, aligned to the larger operand and truncated.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int     ea, eb, fa, fb, e_big, e_sm, d, e;
    bit     sa, sb, s_big, s_sm, neg;
    longint ma, mb, m_big, m_sm, m_al, total, mag;
    ea = int'(a[30:23]);  fa = int'(a[22:0]);  sa = a[31];
    eb = int'(b[30:23]);  fb = int'(b[22:0]);  sb = b[31] ^ sub;
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
        (ea == 255 && eb == 255 && sa != sb))
      return {3'b000, 32'h7FC0_0000};
    if (ea == 255) return {3'b000, sa, 8'hFF, 23'd0};
    if (eb == 255) return {3'b000, sb, 8'hFF, 23'd0};
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + fa;
    mb = (eb == 0) ? 0 : (longint'(1) << 23) + fb;
    if (((longint'(ea) << 24) + ma) >= ((longint'(eb) << 24) + mb)) begin
      e_big = ea; m_big = ma; s_big = sa; e_sm = eb; m_sm = mb; s_sm = sb;
    end else begin
      e_big = eb; m_big = mb; s_big = sb; e_sm = ea; m_sm = ma; s_sm = sa;
    end
    d     = e_big - e_sm;
    m_al  = (d >= 24) ? 0 : (m_sm >> d);
    total = (s_big ? -m_big : m_big) + (s_sm ? -m_al : m_al);
    if (total == 0) return {3'b001, 32'h0};
    neg = (total < 0);
    mag = neg ? -total : total;
    e   = e_big;
    while (mag >= (longint'(1) << 24)) begin mag = mag >> 1; e++; end
    while (mag <  (longint'(1) << 23)) begin mag = mag << 1; e--; end
    if (e >= 255) return {3'b010, neg, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b101, neg, 31'd0};
    return {3'b000, neg, 8'(e), 23'(mag)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    f = 23'($urandom);
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; f = f | 23'd1; end
      3:       e = 8'($urandom_range(252, 254));
      4:       e = 8'($urandom_range(1, 4));
      default: e = 8'($urandom_range(118, 136));
    endcase
    return {s, e, f};
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [34:0] expv, input bit track);
    int budget;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 35'(in_ready), 35'd1);
      in_valid = 1'b0;
      return;
    end
    // Accepted on the coming rising edge, which is edge number cyc+1.
    if (track) begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1 out_ready = ready_random ? 1'($urandom_range(0, 1)) : ready_force;
    end
  endtask

  task automatic run_monitor();
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got out_valid=1, required no pending operation (t=%0t)", $time);
        end else begin
          // out_valid is first sampled by the next rising edge, cyc+1.
          check("latency", 35'((cyc + 1) - acc_q.pop_front()), 35'd4);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got 0x%h, required no result (t=%0t)", out_result, $time);
        end else begin
          check("result", {out_flags, out_result}, exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 35'(exp_q.size()), 35'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          budget;
    logic [31:0] a, b;
    logic        sub;

    fork
      run_monitor();
      drive_ready();
    join_none

    // Reset and the first cycle after it
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",   35'(in_ready),   35'd1);
    check("rst_out_valid",  35'(out_valid),  35'd0);
    check("rst_out_result", 35'(out_result), 35'd0);
    check("rst_out_flags",  35'(out_flags),  35'd0);
    check("rst_state",      35'(state),      35'(IDLE));

    // Directed cases, result taken immediately
    ready_force = 1'b1;
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h4000_0000}, 1'b1);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, {3'b001, 32'h0000_0000}, 1'b1);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, {3'b010, 32'h7F80_0000}, 1'b1);
    issue(32'h7F80_0000, 32'h7F80_0000, 1'b1, {3'b000, 32'h7FC0_0000}, 1'b1);
    issue(32'h3F80_0000, 32'h3380_0000, 1'b0, {3'b000, 32'h3F80_0000}, 1'b1);
    issue(32'h0080_0001, 32'h0080_0000, 1'b1, {3'b101, 32'h0000_0000}, 1'b1);
    issue(32'h8080_0001, 32'h8080_0000, 1'b1, {3'b101, 32'h8000_0000}, 1'b1);
    issue(32'h0040_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h3F80_0000}, 1'b1);
    issue(32'h3F80_0000, 32'hFF80_0000, 1'b1, {3'b000, 32'h7F80_0000}, 1'b1);
    issue(32'h7FC1_2345, 32'h3F80_0000, 1'b0, {3'b000, 32'h7FC0_0000}, 1'b1);
    drain();

    // Back-pressure: hold the result for 3 cycles, offer a new operand meanwhile
    ready_force = 1'b0;
    issue(32'h4000_0000, 32'h3F80_0000, 1'b1, {3'b000, 32'h3F80_0000}, 1'b1);
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("stall_valid_seen", 35'(out_valid), 35'd1);
    for (int k = 0; k < 3; k++) begin
      in_a = $urandom; in_b = $urandom; in_sub = 1'b0; in_valid = 1'b1;
      check("stall_result",   35'(out_result), 35'h3F80_0000);
      check("stall_flags",    35'(out_flags),  35'd0);
      check("stall_in_ready", 35'(in_ready),   35'd0);
      @(negedge clk);
    end
    check("stall_state",  35'(state),      35'(DONE));
    check("stall_result", 35'(out_result), 35'h3F80_0000);
    in_valid    = 1'b0;
    ready_force = 1'b1;
    drain();

    // Reset while the operation sits in ADD; nothing must come out of it
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 35'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_add", 35'(state), 35'(ADD));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_state",     35'(state),     35'(IDLE));
    check("abort_out_valid", 35'(out_valid), 35'd0);
    check("abort_in_ready",  35'(in_ready),  35'd1);
    repeat (6) @(negedge clk);
    issue(32'h4000_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h4040_0000}, 1'b1);
    drain();

    // Randomized operands with random back-pressure
    ready_random = 1'b1;
    for (int n = 0; n < 80; n++) begin
      a   = rand_op();
      sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        // Near-cancellation: same sign, nearby magnitude, effective subtract
        b   = a ^ 32'($urandom_range(0, 255));
        sub = 1'b1;
      end else begin
        b = rand_op();
      end
      issue(a, b, sub, model(a, b, sub), 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
